ram_explorer: RTL

Parametrised successor to the switch-driven LPM RAM board test. A synchronous single-port RAM sits behind a small controller that takes asynchronous board inputs (switches/keys). The controller provides:
- one write per write-request edge, instead of writing every clock while the switch is held;
- a full-memory clear sweep;
- an auto-scan mode that walks every address for display.

The board top level decodes cur_addr, wr_data_q and rd_data onto the HEX displays with the existing decoder.

---
 rtl/ram_explorer_pkg.sv | 21 ++
 rtl/ram_explorer_sync_edge.sv | 34 +++
 rtl/ram_explorer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ram_explorer_pkg.sv
// Shared types and sizing helpers for the RAM explorer board test.
// The optional auto-scan mode is enabled by defining RAM_SCAN_EN.
package ram_explorer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_SCAN  = 2'd3
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Width that holds the scan divider count 0 .. scan_div-1.
  function automatic int scan_div_w(input int scan_div);
    return $clog2(scan_div);
  endfunction

endpackage

// File: rtl/ram_explorer_sync_edge.sv
// Two-flop synchroniser for asynchronous board inputs, with a rising-edge
// strobe that is high for the first cycle the synchronised bit reads 1.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/ram_explorer.sv
// Switch-driven RAM explorer: edge-triggered single writes, clear sweep and,
// when RAM_SCAN_EN is defined, an auto-scan walk over every address.
module ram_explorer
  import ram_explorer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 25000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_req,
  input  logic              clr_req,
  input  logic              scan_mode,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [DATA_W-1:0] wr_data_q,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              write_done
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int BUS_W = ADDR_W + DATA_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [BUS_W-1:0]  w_bus_s;
  logic [BUS_W-1:0]  w_bus_rise_unused;
  logic [1:0]        w_req_s_unused;
  logic [1:0]        w_req_rise;
  logic [ADDR_W-1:0] w_addr_s;
  logic [DATA_W-1:0] w_data_s;
  logic              w_scan_s;
  logic              w_clr_e;
  logic              w_wr_e;

  sync_edge #(.W(BUS_W)) u_bus_sync (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .i_d    ({scan_mode, addr_in, data_in}),
    .o_q    (w_bus_s),
    .o_rise (w_bus_rise_unused)
  );

  sync_edge #(.W(2)) u_req_sync (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .i_d    ({clr_req, wr_req}),
    .o_q    (w_req_s_unused),
    .o_rise (w_req_rise)
  );

  assign {w_scan_s, w_addr_s, w_data_s} = w_bus_s;
  assign w_clr_e = w_req_rise[1];
  assign w_wr_e  = w_req_rise[0];

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_done;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_busy;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_cur_addr;

`ifdef RAM_SCAN_EN
  localparam int DIV_W = scan_div_w(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  logic [ADDR_W-1:0] r_scan;
  logic [DIV_W-1:0]  r_div;
`else
  localparam int SCAN_DIV_UNUSED = SCAN_DIV;
  logic w_scan_unused;
  assign w_scan_unused = w_scan_s;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  // Edges seen in WRITE or CLEAR have no branch here, so they are dropped.
  always_comb begin
    // NOTE: default first so no path leaves w_nxt unassigned (no latch).
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_e)     w_nxt = ST_CLEAR;
        else if (w_wr_e) w_nxt = ST_WRITE;
`ifdef RAM_SCAN_EN
        else if (w_scan_s) w_nxt = ST_SCAN;
`endif
      end
      ST_WRITE: w_nxt = ST_IDLE;
      ST_CLEAR: if (r_addr == LAST_ADDR) w_nxt = ST_IDLE;
`ifdef RAM_SCAN_EN
      ST_SCAN: begin
        if (w_clr_e)       w_nxt = ST_CLEAR;
        else if (w_wr_e)   w_nxt = ST_WRITE;
        else if (!w_scan_s) w_nxt = ST_IDLE;
      end
`endif
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_we       = 1'b0;
    w_waddr    = r_wr_addr;
    w_wdata    = r_wr_data;
    w_cur_addr = r_addr;
    case (r_state)
      ST_WRITE: begin
        w_busy = 1'b1;
        w_we   = 1'b1;
      end
      ST_CLEAR: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_addr;
        w_wdata = '0;
      end
`ifdef RAM_SCAN_EN
      ST_SCAN: w_cur_addr = r_scan;
`endif
      default: ;
    endcase
  end

  // r_addr is the manual address outside CLEAR and the sweep pointer inside it.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_addr    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_WRITE);
      if (r_state == ST_CLEAR)     r_addr <= r_addr + ADDR_W'(1);
      else if (w_nxt == ST_CLEAR)  r_addr <= '0;
      else                         r_addr <= w_addr_s;
      if (w_nxt == ST_WRITE) begin
        r_wr_addr <= w_addr_s;
        r_wr_data <= w_data_s;
      end
    end
  end

`ifdef RAM_SCAN_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scan <= '0;
      r_div  <= '0;
    end else if (r_state == ST_SCAN) begin
      if (w_clr_e || w_wr_e) begin
        r_scan <= '0;
        r_div  <= '0;
      end else if (r_div == DIV_LAST) begin
        r_scan <= r_scan + ADDR_W'(1);
        r_div  <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end else begin
      r_div <= '0;
    end
  end
`endif

  // NOTE: the RAM array has no reset; contents survive RESET_N by design and
  // a reset would also stop it mapping onto block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_rd_data <= '0;
    else          r_rd_data <= r_mem[w_cur_addr];
  end

  assign cur_addr   = w_cur_addr;
  assign wr_data_q  = w_data_s;
  assign rd_data    = r_rd_data;
  assign busy       = w_busy;
  assign write_done = r_done;

endmodule
